// File: rtl/chan_sequencer_if.sv
// Sample-stream producer bus: frame input, config write port and serialized output.
interface chan_sequencer_if #(
    parameter int unsigned W_CHAN    = 5,
    parameter int unsigned N_CHAN    = 8,
    parameter int unsigned W_DATA    = 18,
    parameter int unsigned W_WR_ADDR = 16,
    parameter int unsigned W_WR_CHAN = 16,
    parameter int unsigned W_WR_DATA = 48
);
    logic                     sample_stb;
    logic [N_CHAN*W_DATA-1:0] samples_in;
    logic                     wr_en;
    logic [W_WR_ADDR-1:0]     wr_addr;
    logic [W_WR_CHAN-1:0]     wr_chan;
    logic [W_WR_DATA-1:0]     wr_data;
    logic                     dv_out;
    logic [W_CHAN-1:0]        chan_out;
    logic [W_DATA-1:0]        data_out;
    logic                     busy_out;
    logic                     overrun_out;

    // Sequencer side
    modport slave (
        input  sample_stb, samples_in, wr_en, wr_addr, wr_chan, wr_data,
        output dv_out, chan_out, data_out, busy_out, overrun_out
    );

    // Frame source / config master side
    modport master (
        output sample_stb, samples_in, wr_en, wr_addr, wr_chan, wr_data,
        input  dv_out, chan_out, data_out, busy_out, overrun_out
    );
endinterface

// File: rtl/chan_sequencer.sv
// Captures a parallel frame of channel samples and serializes the enabled
// channels in ascending order, one per cycle, onto the dv/chan/data stream.
module chan_sequencer #(
    parameter int unsigned W_CHAN    = 5,
    parameter int unsigned N_CHAN    = 8,
    parameter int unsigned W_DATA    = 18,
    parameter int unsigned W_WR_ADDR = 16,
    parameter int unsigned W_WR_CHAN = 16,
    parameter int unsigned W_WR_DATA = 48,
    parameter logic [W_WR_ADDR-1:0] ADDR_CHAN_EN = W_WR_ADDR'(16'h0050),
    parameter logic [W_WR_ADDR-1:0] ADDR_OVR_CLR = W_WR_ADDR'(16'h0051)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    chan_sequencer_if.slave  bus
);

    localparam int unsigned W_IDX   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int unsigned W_FRAME = N_CHAN * W_DATA;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [N_CHAN-1:0]   en_q, en_d;
    logic [N_CHAN-1:0]   pend_q, pend_d;
    logic [W_FRAME-1:0]  buf_q, buf_d;
    logic                dv_q, dv_d;
    logic [W_CHAN-1:0]   chan_q, chan_d;
    logic [W_DATA-1:0]   data_q, data_d;
    logic                ovr_q, ovr_d;

    logic [W_IDX-1:0]    low_idx_c;
    logic [N_CHAN-1:0]   pend_rest_c;
    logic                last_c;
    logic                accept_c;
    logic                wr_en_hit_c;
    logic                wr_clr_c;

    // Only bit 0 of the config data carries the enable value
    logic                unused_wr_data;
    assign unused_wr_data = ^bus.wr_data[W_WR_DATA-1:1];

    // Lowest pending channel and the pending set left once it is emitted
    always_comb begin
        low_idx_c = '0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx_c = W_IDX'(i);
            end
        end
        pend_rest_c = pend_q & ~(N_CHAN'(1) << low_idx_c);
    end

    // Acceptance window and config write decode
    always_comb begin
        last_c      = (state_q == EMIT) && (pend_rest_c == '0);
        accept_c    = (state_q == IDLE) || last_c;
        wr_en_hit_c = bus.wr_en && (bus.wr_addr == ADDR_CHAN_EN)
                      && (bus.wr_chan < W_WR_CHAN'(N_CHAN));
        wr_clr_c    = bus.wr_en && (bus.wr_addr == ADDR_OVR_CLR);
    end

    // Next-state: emission, capture, overrun flag and enable mask
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        dv_d    = 1'b0;
        chan_d  = chan_q;
        data_d  = data_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
            end
            EMIT: begin
                dv_d   = 1'b1;
                chan_d = W_CHAN'(low_idx_c);
                data_d = buf_q[low_idx_c * W_DATA +: W_DATA];
                pend_d = pend_rest_c;
                if (pend_rest_c == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear first so that a simultaneous overrun wins
        if (wr_clr_c) begin
            ovr_d = 1'b0;
        end

        if (bus.sample_stb) begin
            if (accept_c) begin
                // An all-disabled mask makes the strobe a no-op
                if (en_q != '0) begin
                    buf_d   = bus.samples_in;
                    pend_d  = en_q;
                    state_d = EMIT;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end

        // Mask is snapshotted into pending at capture, so in-flight frames are unaffected
        if (wr_en_hit_c) begin
            en_d[bus.wr_chan[W_IDX-1:0]] = bus.wr_data[0];
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            en_q    <= '1;
            pend_q  <= '0;
            buf_q   <= '0;
            dv_q    <= 1'b0;
            chan_q  <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            dv_q    <= dv_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.dv_out      = dv_q;
    assign bus.chan_out    = chan_q;
    assign bus.data_out    = data_q;
    assign bus.busy_out    = (state_q == EMIT);
    assign bus.overrun_out = ovr_q;

endmodule
